pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumes stall and redirect requests and drives the pipeline-register enables and flushes.
//  Stall requests come from hazard detection (load-use and memory structural).
//  Redirect requests come from EX/MEM (taken branch/jump).
//  Holds PC and IF/ID, injects ID/EX bubbles, and squashes wrong-path instructions.
//  Runs a multi-cycle flush window and a stall watchdog.
//  Sits between hazard detection and the PC / IF_ID / ID_EX / EX_MEM registers.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles IF/ID+ID/EX flushed per redirect (1..7)
//  MAX_STALL     15  consecutive stall cycles before stall_timeout sets (1..255)
//  STALL_W       8   width of consecutive-stall counter; must hold MAX_STALL
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  hz_stall        in   1   stall request (load-use or EX_MEM mem access)
//  branch_taken    in   1   redirect request from EX_MEM; PC loads target this cycle
//  pc_write_en     out  1   PC register enable
//  if_id_write_en  out  1   IF_ID register enable
//  if_id_flush     out  1   IF_ID clears to NOP
//  id_ex_flush     out  1   ID_EX control fields zeroed (bubble)
//  ex_mem_flush    out  1   EX_MEM control fields zeroed
//  ctrl_state      out  2   FSM state: 00 RUN, 01 STALL, 10 FLUSH
//  stall_timeout   out  1   sticky watchdog flag
//  perf_stall_cyc  out  32  stall-cycle count (STALL_PERF_EN only, else 0)
//  perf_flush_cnt  out  32  redirect count (STALL_PERF_EN only, else 0)
// BEHAVIOUR
//  Clock/reset: single clock clk; reset rst is synchronous and active-high.
//  Output timing:
//  - Enable/flush outputs are combinational from state and inputs (same-cycle response).
//  - ctrl_state, counters and stall_timeout are registered.
//  While rst=1:
//  - pc_write_en=0, if_id_write_en=0; all three flush outputs =1.
//  - Next state RUN; flush counter =0, stall counter =0, stall_timeout=0, perf counters =0.
//  Priority: branch_taken > hz_stall, in every state.
//  RUN:
//  - No requests: pc_write_en=1, if_id_write_en=1, flushes=0.
//  - hz_stall=1 (no branch): pc_write_en=0, if_id_write_en=0, id_ex_flush=1; next STALL.
//  - branch_taken=1: pc_write_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=0.
//    Next FLUSH with fcnt=FLUSH_CYCLES-1; if FLUSH_CYCLES==1, stay RUN.
//  STALL:
//  - Same outputs as the RUN stall case while hz_stall=1.
//  - hz_stall=0: behave as RUN no-request (release in the same cycle); next RUN.
//  - branch_taken=1: abandon stall; apply the RUN redirect outputs and transition.
//  FLUSH:
//  - if_id_flush=1, id_ex_flush=1, pc_write_en=1, if_id_write_en=1.
//  - fcnt decrements each cycle; at fcnt==1 next state is RUN.
//  - hz_stall is ignored (wrong-path source).
//  - branch_taken=1: reload fcnt=FLUSH_CYCLES-1 and stay in FLUSH.
//  ex_mem_flush=1 only during rst; reserved for trap use.
//  Watchdog:
//  - scnt increments each cycle hz_stall=1 && state!=FLUSH && !branch_taken; saturates at all-ones.
//  - scnt clears on any other cycle.
//  - stall_timeout sets on the clock edge where scnt reaches MAX_STALL; cleared only by rst.
//  Reset mid-FLUSH or mid-STALL: abandons the window; first post-reset cycle is RUN.
// CONFIGURATION
//  STALL_PERF_EN defined:
//  - perf_stall_cyc +1 per cycle with pc_write_en=0 and rst=0.
//  - perf_flush_cnt +1 per accepted branch_taken.
//  - Both 32-bit, wrap modulo 2^32.
//  STALL_PERF_EN undefined: no counter flops; both ports tied to 32'd0.
// TESTING
//  T1 reset: rst=1 for 2 cycles.
//     -> enables 0, flushes 1; then ctrl_state=00, pc_write_en=1.
//  T2 load-use: hz_stall=1 for 1 cycle.
//     -> pc_write_en=0, id_ex_flush=1 that cycle; next cycle RUN, enables 1.
//  T3 redirect (FLUSH_CYCLES=2): branch_taken pulse.
//     -> if_id_flush=1 for 2 cycles, ctrl_state 00 -> 10 -> 00.
//  T4 collision: hz_stall=1 and branch_taken=1 together.
//     -> pc_write_en=1, flushes asserted, state FLUSH, scnt=0.
//  T5 watchdog (MAX_STALL=15): hz_stall=1 for 15 cycles.
//     -> stall_timeout=1 from cycle 16; stays 1 after stall drops.
//  T6 perf (STALL_PERF_EN): 3 stall cycles + 2 redirects.
//     -> perf_stall_cyc=3, perf_flush_cnt=2; undefined: both 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Turns hazard-detection stall requests and EX/MEM redirect requests into
//   the enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.
//   It holds the front end on a stall, injects ID/EX bubbles, and squashes
//   wrong-path instructions over a multi-cycle flush window. A watchdog sets
//   a sticky flag after too many consecutive stall cycles.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   hz_stall       in   stall request (load-use / memory structural)
//   branch_taken   in   redirect request from EX/MEM (wins over hz_stall)
//   pc_write_en    out  PC register enable
//   if_id_write_en out  IF/ID register enable
//   if_id_flush    out  IF/ID clears to NOP
//   id_ex_flush    out  ID/EX control fields zeroed (bubble)
//   ex_mem_flush   out  EX/MEM control fields zeroed (asserted only in reset)
//   ctrl_state     out  registered FSM state: 00 RUN, 01 STALL, 10 FLUSH
//   stall_timeout  out  sticky watchdog flag, cleared only by rst
//   perf_stall_cyc out  cycles with pc_write_en=0 outside reset
//   perf_flush_cnt out  accepted redirects
//
// Configuration macro STALL_PERF_EN: when defined, the two perf counters
// are built; when undefined they have no flops and read as zero.

module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // 1..7
    parameter int MAX_STALL    = 15,  // 1..255
    parameter int STALL_W      = 8    // must hold MAX_STALL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        branch_taken,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [1:0]  ctrl_state,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_e;

    localparam logic [2:0]         FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);

    state_e             state_q, state_d;
    logic [2:0]         fcnt_q, fcnt_d;
    logic [STALL_W-1:0] scnt_q, scnt_d;
    logic               timeout_q, timeout_d;

    // Outputs and next state. Redirect beats everything (except reset) in
    // every state; the remaining flush-window cycles come from fcnt.
    always_comb begin
        state_d        = RUN;
        fcnt_d         = fcnt_q;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        if (rst) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            ex_mem_flush   = 1'b1;
            fcnt_d         = 3'd0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            fcnt_d      = FCNT_RELOAD;
            // A one-cycle window is fully covered by this cycle's flush.
            state_d     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (state_q == FLUSH) begin
            // hz_stall is ignored here: its source is a wrong-path instruction.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            fcnt_d      = fcnt_q - 3'd1;
            state_d     = (fcnt_q == 3'd1) ? RUN : FLUSH;
        end else if (hz_stall) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            state_d        = STALL;
        end
    end

    // Watchdog: count consecutive effective stall cycles, saturating.
    always_comb begin
        scnt_d = '0;
        if (hz_stall && state_q != FLUSH && !branch_taken)
            scnt_d = (&scnt_q) ? scnt_q : scnt_q + 1'b1;
        timeout_d = timeout_q | (scnt_d == STALL_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            fcnt_q    <= 3'd0;
            scnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            scnt_q    <= scnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ctrl_state    = state_q;
    assign stall_timeout = timeout_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (!pc_write_en)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (branch_taken)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cyc = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with default parameters
// (FLUSH_CYCLES=2, MAX_STALL=15). Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns later, well away from the next edge.

module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hz_stall;
    logic        branch_taken;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic [1:0]  ctrl_state;
    logic        stall_timeout;
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .hz_stall       (hz_stall),
        .branch_taken   (branch_taken),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .ctrl_state     (ctrl_state),
        .stall_timeout  (stall_timeout),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock, then let inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bundle of {pc_we, ifid_we, if_id_flush, id_ex_flush, ex_mem_flush}
    function automatic logic [4:0] outs();
        return {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_flush};
    endfunction

    task automatic test_reset();
        rst = 1'b1; hz_stall = 1'b0; branch_taken = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b00111) begin
            errors++; $display("FAIL reset_outs got %b want 00111", outs());
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b00) begin
            errors++; $display("FAIL reset_state got %b want 00", ctrl_state);
        end
        checks++;
        if (outs() !== 5'b11000) begin
            errors++; $display("FAIL post_reset_outs got %b want 11000", outs());
        end
        checks++;
        if (stall_timeout !== 1'b0 || perf_stall_cyc !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_regs got to=%b ps=%0d pf=%0d want 0 0 0",
                               stall_timeout, perf_stall_cyc, perf_flush_cnt);
        end
    endtask

    task automatic test_load_use();
        hz_stall = 1'b1;
        #1;
        checks++;
        if (outs() !== 5'b00010) begin
            errors++; $display("FAIL load_use_outs got %b want 00010", outs());
        end
        tick();
        hz_stall = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b01 || outs() !== 5'b11000) begin
            errors++; $display("FAIL stall_release got st=%b outs=%b want 01 11000", ctrl_state, outs());
        end
        tick();
        checks++;
        if (ctrl_state !== 2'b00) begin
            errors++; $display("FAIL load_use_back_run got %b want 00", ctrl_state);
        end
    endtask

    task automatic test_redirect();
        branch_taken = 1'b1;
        #1;
        checks++;
        if (outs() !== 5'b11110 || ctrl_state !== 2'b00) begin
            errors++; $display("FAIL redirect_c0 got st=%b outs=%b want 00 11110", ctrl_state, outs());
        end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b11110 || ctrl_state !== 2'b10) begin
            errors++; $display("FAIL redirect_c1 got st=%b outs=%b want 10 11110", ctrl_state, outs());
        end
        tick();
        checks++;
        if (outs() !== 5'b11000 || ctrl_state !== 2'b00) begin
            errors++; $display("FAIL redirect_c2 got st=%b outs=%b want 00 11000", ctrl_state, outs());
        end
    endtask

    task automatic test_collision();
        hz_stall = 1'b1; branch_taken = 1'b1;
        #1;
        checks++;
        if (outs() !== 5'b11110) begin
            errors++; $display("FAIL collision_outs got %b want 11110", outs());
        end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b10 || dut.scnt_q !== 8'd0) begin
            errors++; $display("FAIL collision_state got st=%b scnt=%0d want 10 0", ctrl_state, dut.scnt_q);
        end
        // hz_stall is still high but ignored inside the flush window
        checks++;
        if (outs() !== 5'b11110) begin
            errors++; $display("FAIL flush_ignores_stall got %b want 11110", outs());
        end
        hz_stall = 1'b0;
        tick();
        checks++;
        if (ctrl_state !== 2'b00) begin
            errors++; $display("FAIL collision_end got %b want 00", ctrl_state);
        end
    endtask

    task automatic test_flush_reload();
        branch_taken = 1'b1;
        tick();                 // now FLUSH, fcnt=1
        tick();                 // branch again in FLUSH: reload, stay FLUSH
        branch_taken = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b10) begin
            errors++; $display("FAIL flush_reload got %b want 10", ctrl_state);
        end
        tick();
        checks++;
        if (ctrl_state !== 2'b00) begin
            errors++; $display("FAIL flush_reload_end got %b want 00", ctrl_state);
        end
    endtask

    task automatic test_stall_abandon();
        hz_stall = 1'b1;
        tick();                 // STALL
        branch_taken = 1'b1;
        #1;
        checks++;
        if (ctrl_state !== 2'b01 || outs() !== 5'b11110) begin
            errors++; $display("FAIL stall_abandon got st=%b outs=%b want 01 11110", ctrl_state, outs());
        end
        tick();
        hz_stall = 1'b0; branch_taken = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b10) begin
            errors++; $display("FAIL stall_abandon_state got %b want 10", ctrl_state);
        end
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        hz_stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (stall_timeout !== 1'b0) begin
            errors++; $display("FAIL watchdog_early got %b want 0", stall_timeout);
        end
        tick();                 // 15th stall edge: scnt reaches 15
        checks++;
        if (stall_timeout !== 1'b1) begin
            errors++; $display("FAIL watchdog_set got %b want 1", stall_timeout);
        end
        hz_stall = 1'b0;
        tick();
        tick();
        checks++;
        if (stall_timeout !== 1'b1 || ctrl_state !== 2'b00) begin
            errors++; $display("FAIL watchdog_sticky got to=%b st=%b want 1 00", stall_timeout, ctrl_state);
        end
    endtask

    task automatic test_reset_mid_window();
        hz_stall = 1'b1;
        tick();                 // STALL
        rst = 1'b1;
        tick();
        rst = 1'b0; hz_stall = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b00 || stall_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stall got st=%b to=%b want 00 0", ctrl_state, stall_timeout);
        end
        branch_taken = 1'b1;
        tick();                 // FLUSH
        branch_taken = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'b00 || outs() !== 5'b11000) begin
            errors++; $display("FAIL reset_mid_flush got st=%b outs=%b want 00 11000", ctrl_state, outs());
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_s, exp_f;
`ifdef STALL_PERF_EN
        exp_s = 32'd3; exp_f = 32'd2;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hz_stall = 1'b1;
        tick(); tick(); tick();
        hz_stall = 1'b0;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        tick();
        checks++;
        if (perf_stall_cyc !== exp_s) begin
            errors++; $display("FAIL perf_stall got %0d want %0d", perf_stall_cyc, exp_s);
        end
        checks++;
        if (perf_flush_cnt !== exp_f) begin
            errors++; $display("FAIL perf_flush got %0d want %0d", perf_flush_cnt, exp_f);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_collision();
        test_flush_reload();
        test_stall_abandon();
        test_watchdog();
        test_reset_mid_window();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
